// File: rtl/microcode_dispatch.sv
// microcode_dispatch: fetches an instruction word, issues its opcode to the
// microcode sequencer with a one-cycle sos pulse, waits for eos, advances pc.
// Optional WAIT-state watchdog: define MICROCODE_DISPATCH_WATCHDOG_EN.
module microcode_dispatch #(
   parameter int unsigned PC_WIDTH = 8,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_data,
   input  logic                imem_valid,
   output logic [5:0]          opcode,
   output logic                sos,
   input  logic                eos,
   input  logic                pc_ld,
   input  logic [PC_WIDTH-1:0] pc_ld_val,
   output logic [PC_WIDTH-1:0] pc,
   output logic                busy,
   output logic                halted,
   output logic                fault
);

   localparam logic [5:0] HALT_OPCODE = 6'h3F;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_HALT  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [31:0]         ir;
   logic [31:0]         ir_nxt;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic [PC_WIDTH-1:0] pc_adv;
   logic                ir_unused;

`ifdef MICROCODE_DISPATCH_WATCHDOG_EN
   localparam int unsigned CNT_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   logic [CNT_WIDTH-1:0] wd_cnt;
   logic [CNT_WIDTH-1:0] wd_cnt_nxt;
`else
   localparam int unsigned timeout_unused = TIMEOUT;
`endif

   // Only the opcode field drives the sequencer; the rest of ir is held for completeness.
   assign ir_unused = ^ir[25:0];
   assign opcode    = ir[31:26];
   assign imem_addr = pc;

   // Next sequential pc: redirect target or pc + 4, wrapping at 2^PC_WIDTH.
   assign pc_adv = pc_ld ? pc_ld_val : pc + PC_WIDTH'(4);

   // Next-state, ir capture, pc update and watchdog count.
   always_comb begin
      state_nxt = state;
      ir_nxt    = ir;
      pc_nxt    = pc;
`ifdef MICROCODE_DISPATCH_WATCHDOG_EN
      wd_cnt_nxt = wd_cnt;
`endif
      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (imem_valid) begin
               ir_nxt    = imem_data;
               state_nxt = (imem_data[31:26] == HALT_OPCODE) ? S_HALT : S_ISSUE;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (eos) begin
               pc_nxt    = pc_adv;
               state_nxt = run ? S_FETCH : S_IDLE;
            end else if (state == S_ISSUE) begin
               state_nxt = S_WAIT;
`ifdef MICROCODE_DISPATCH_WATCHDOG_EN
               wd_cnt_nxt = '0;
`endif
            end
`ifdef MICROCODE_DISPATCH_WATCHDOG_EN
            else if (wd_cnt == CNT_LAST) begin
               state_nxt = S_FAULT;
            end else begin
               wd_cnt_nxt = wd_cnt + CNT_WIDTH'(1);
            end
`endif
         end
         S_HALT, S_FAULT: begin
            state_nxt = state;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and registered status outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= '0;
         ir       <= '0;
         imem_req <= 1'b0;
         sos      <= 1'b0;
         busy     <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         ir       <= ir_nxt;
         imem_req <= (state_nxt == S_FETCH);
         sos      <= (state_nxt == S_ISSUE);
         busy     <= (state_nxt == S_FETCH) || (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
         halted   <= (state_nxt == S_HALT);
      end
   end

`ifdef MICROCODE_DISPATCH_WATCHDOG_EN
   // Watchdog counter and sticky fault flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         fault  <= 1'b0;
      end else begin
         wd_cnt <= wd_cnt_nxt;
         fault  <= (state_nxt == S_FAULT);
      end
   end
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_dispatch.sv
// tb_microcode_dispatch: directed bench with a cycle-level reference model
// compared against every DUT output on each falling edge.
module tb_microcode_dispatch;

   localparam int PC_W    = 8;
   localparam int TO      = 4;
   localparam int PC_SPAN = 1 << PC_W;
`ifdef MICROCODE_DISPATCH_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            run;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_data;
   logic            imem_valid;
   logic [5:0]      opcode;
   logic            sos;
   logic            eos;
   logic            pc_ld;
   logic [PC_W-1:0] pc_ld_val;
   logic [PC_W-1:0] pc;
   logic            busy;
   logic            halted;
   logic            fault;

   microcode_dispatch #(.PC_WIDTH(PC_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
      .opcode(opcode), .sos(sos), .eos(eos), .pc_ld(pc_ld), .pc_ld_val(pc_ld_val),
      .pc(pc), .busy(busy), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   // ---------------- environment: memory and sequencer stand-ins ----------------
   logic [31:0]     mem [64];
   int              lat;          // memory wait cycles before valid
   int              req_cnt;
   bit              eos_en;
   int              eos_lat;      // eos asserted this many cycles after the sos cycle
   int              since;
   bit              ld_en;
   logic [PC_W-1:0] ld_sos_pc, ld_eos_pc, sos_val, eos_val;

   assign imem_data  = mem[imem_addr[7:2]];
   assign imem_valid = imem_req && (req_cnt >= lat);
   assign eos        = eos_en && (since == eos_lat);
   assign pc_ld      = ld_en && ((sos && imem_addr == ld_sos_pc) || (eos && imem_addr == ld_eos_pc));
   assign pc_ld_val  = sos ? sos_val : eos_val;

   always @(posedge clk) begin
      req_cnt <= imem_req ? req_cnt + 1 : 0;
      if (rst)                         since <= 0;
      else if (sos)                    since <= 1;
      else if (since != 0 && since < 1000) since <= since + 1;
   end

   // ---------------- reference model ----------------
   typedef enum {P_IDLE, P_FETCH, P_ISSUE, P_WAIT, P_HALT, P_FAULT} phase_t;
   phase_t     ph;
   int         m_pc;
   logic [5:0] m_op;
   int         m_stall;
   int         m_fcnt;
   bit         m_ok = 1'b0;
   bit         done = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         ph = P_IDLE; m_pc = 0; m_op = 6'h00; m_stall = 0; m_fcnt = 0; m_ok = 1'b1;
      end else if (m_ok) begin
         case (ph)
            P_IDLE: if (run) begin ph = P_FETCH; m_fcnt = 0; end
            P_FETCH: begin
               if (m_fcnt >= lat) begin
                  m_op = mem[m_pc / 4][31:26];
                  ph   = (m_op == 6'h3F) ? P_HALT : P_ISSUE;
               end else m_fcnt++;
            end
            P_ISSUE, P_WAIT: begin
               if (eos) begin
                  m_pc   = pc_ld ? int'(pc_ld_val) : (m_pc + 4) % PC_SPAN;
                  ph     = run ? P_FETCH : P_IDLE;
                  m_fcnt = 0;
               end else if (ph == P_ISSUE) begin
                  ph = P_WAIT; m_stall = 0;
               end else begin
                  m_stall++;
                  if (WD && m_stall == TO) ph = P_FAULT;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (m_ok && !done) begin
         check("cmp_req",    32'(imem_req),  32'(ph == P_FETCH));
         check("cmp_addr",   32'(imem_addr), 32'(m_pc));
         check("cmp_pc",     32'(pc),        32'(m_pc));
         check("cmp_opcode", 32'(opcode),    32'(m_op));
         check("cmp_sos",    32'(sos),       32'(ph == P_ISSUE));
         check("cmp_busy",   32'(busy),      32'(ph == P_FETCH || ph == P_ISSUE || ph == P_WAIT));
         check("cmp_halted", 32'(halted),    32'(ph == P_HALT));
         check("cmp_fault",  32'(fault),     32'(ph == P_FAULT));
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic clear_env();
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      lat = 0; eos_en = 1'b1; eos_lat = 1; ld_en = 1'b0;
      ld_sos_pc = 8'hFF; ld_eos_pc = 8'hFF; sos_val = 8'h00; eos_val = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int sos_k [$];
      int op_at [32];
      int pc_at [32];
      int flt_at[32];
      int addrs [$];
      int reqs;
      bit op_bad;

      rst = 1'b1; run = 1'b0; req_cnt = 0; since = 0;
      clear_env();

      // ---- T1: two instructions then halt at pc=8 ----
      mem[0] = 32'h0400_0000; mem[1] = 32'h0800_0000; mem[2] = 32'hFC00_0000;
      do_reset();
      @(negedge clk);
      check("rst_pc", 32'(pc), 0);
      check("rst_opcode", 32'(opcode), 0);
      check("rst_sos", 32'(sos), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_req", 32'(imem_req), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_fault", 32'(fault), 0);
      step(); run = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (sos) sos_k.push_back(k);
         op_at[k] = int'(opcode); pc_at[k] = int'(pc);
         step();
      end
      check("t1_sos_count", 32'(sos_k.size()), 2);
      if (sos_k.size() == 2) begin
         check("t1_sos0_cycle", 32'(sos_k[0]), 2);
         check("t1_sos1_cycle", 32'(sos_k[1]), 5);
      end
      check("t1_op_before", 32'(op_at[1]), 0);
      check("t1_op_first", 32'(op_at[2]), 32'h01);
      check("t1_op_second", 32'(op_at[5]), 32'h02);
      check("t1_pc_k3", 32'(pc_at[3]), 0);
      check("t1_pc_k4", 32'(pc_at[4]), 4);
      check("t1_pc_k7", 32'(pc_at[7]), 8);
      check("t1_halt_op", 32'(op_at[9]), 32'h3F);
      @(negedge clk);
      check("t1_halted", 32'(halted), 1);
      check("t1_halt_busy", 32'(busy), 0);
      check("t1_halt_pc", 32'(pc), 8);
      reqs = 0;
      for (int k = 0; k < 5; k++) begin step(); @(negedge clk); if (sos) reqs++; end
      check("t1_no_sos_in_halt", 32'(reqs), 0);
      do_reset();
      @(negedge clk);
      check("t1_rst_pc", 32'(pc), 0);
      check("t1_rst_halted", 32'(halted), 0);

      // ---- T2: memory with 3 wait cycles, run dropped in WAIT ----
      clear_env();
      lat = 3; mem[0] = 32'h0C00_0001;
      do_reset(); step(); run = 1'b1;
      sos_k.delete(); reqs = 0; op_bad = 1'b0;
      for (int k = 0; k < 16; k++) begin
         bit s;
         @(negedge clk);
         s = sos;
         if (imem_req) begin reqs++; if (opcode != 6'h00) op_bad = 1'b1; end
         if (s) begin sos_k.push_back(k); op_at[0] = int'(opcode); end
         step();
         if (s) run = 1'b0;
      end
      check("t2_req_cycles", 32'(reqs), 4);
      check("t2_op_stable_in_fetch", 32'(op_bad), 0);
      check("t2_sos_count", 32'(sos_k.size()), 1);
      if (sos_k.size() == 1) check("t2_sos_cycle", 32'(sos_k[0]), 5);
      check("t2_op_captured", 32'(op_at[0]), 32'h03);
      @(negedge clk);
      check("t2_idle_pc", 32'(pc), 4);
      check("t2_idle_busy", 32'(busy), 0);

      // ---- T3: pc_ld ignored in ISSUE, taken with eos ----
      clear_env();
      mem[0] = 32'h0400_0000; mem[1] = 32'h0800_0000; mem[16] = 32'hFC00_0000;
      ld_en = 1'b1; ld_sos_pc = 8'h00; sos_val = 8'h80; ld_eos_pc = 8'h04; eos_val = 8'h40;
      do_reset(); step(); run = 1'b1;
      addrs.delete();
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (imem_req && imem_valid) addrs.push_back(int'(imem_addr));
         step();
      end
      check("t3_fetch_count", 32'(addrs.size()), 3);
      if (addrs.size() == 3) begin
         check("t3_addr0", 32'(addrs[0]), 0);
         check("t3_addr1", 32'(addrs[1]), 4);
         check("t3_addr2", 32'(addrs[2]), 32'h40);
      end
      @(negedge clk);
      check("t3_halted", 32'(halted), 1);

      // ---- T4: pc wrap from 0xFC, run dropped in WAIT ----
      clear_env();
      mem[0] = 32'h0400_0000; mem[63] = 32'h1400_0000;
      ld_en = 1'b1; ld_eos_pc = 8'h00; eos_val = 8'hFC;
      do_reset(); step(); run = 1'b1;
      addrs.delete();
      for (int k = 0; k < 14; k++) begin
         bit s;
         @(negedge clk);
         s = sos && (imem_addr == 8'hFC);
         if (imem_req && imem_valid) addrs.push_back(int'(imem_addr));
         step();
         if (s) run = 1'b0;
      end
      check("t4_fetch_count", 32'(addrs.size()), 2);
      if (addrs.size() == 2) check("t4_addr1", 32'(addrs[1]), 32'hFC);
      @(negedge clk);
      check("t4_wrap_pc", 32'(pc), 0);
      check("t4_req_low", 32'(imem_req), 0);
      check("t4_opcode", 32'(opcode), 32'h05);

      // ---- T5: reset during FETCH, no sos afterwards ----
      clear_env();
      mem[0] = 32'h0400_0000;
      do_reset(); step(); run = 1'b1;
      step();
      rst = 1'b1; run = 1'b0;
      step();
      rst = 1'b0;
      reqs = 0;
      for (int k = 0; k < 6; k++) begin @(negedge clk); if (sos || imem_req) reqs++; step(); end
      check("t5_quiet_after_reset", 32'(reqs), 0);
      check("t5_pc", 32'(pc), 0);

      // ---- T6: eos in the 4th WAIT cycle ----
      clear_env();
      eos_lat = 4; mem[0] = 32'h0400_0000; mem[1] = 32'hFC00_0000;
      do_reset(); step(); run = 1'b1;
      reqs = 0;
      for (int k = 0; k < 14; k++) begin @(negedge clk); if (fault) reqs++; step(); end
      check("t6_no_fault", 32'(reqs), 0);
      check("t6_pc", 32'(pc), 4);
      check("t6_halted", 32'(halted), 1);

`ifdef MICROCODE_DISPATCH_WATCHDOG_EN
      // ---- T7: eos never arrives, watchdog expires ----
      clear_env();
      eos_en = 1'b0; mem[0] = 32'h0400_0000;
      do_reset(); step(); run = 1'b1;
      sos_k.delete();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (sos) sos_k.push_back(k);
         flt_at[k] = int'(fault); pc_at[k] = int'(busy);
         step();
      end
      check("t7_sos_count", 32'(sos_k.size()), 1);
      check("t7_fault_k6", 32'(flt_at[6]), 0);
      check("t7_fault_k7", 32'(flt_at[7]), 1);
      check("t7_fault_sticky", 32'(flt_at[11]), 1);
      check("t7_busy_in_fault", 32'(pc_at[7]), 0);
      check("t7_pc_frozen", 32'(pc), 0);
`endif

      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
